mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide engine for the MIPS datapath, covering MULT, MULTU, DIV and DIVU.
- Sits directly upstream of the HI and LO 32-bit enable/reset registers.
- Drives the HI and LO data inputs and their shared write enable.
- Uses one clock, a start/busy/done handshake and fixed 34-cycle occupancy.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is verified.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- start  input  1  request; accepted only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  input  WIDTH  multiplicand or dividend (rs); sampled with start
- b  input  WIDTH  multiplier or divisor (rt); sampled with start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; results valid
- hiloWrite  output  1  equals done; drives writeEnable of the HI and LO registers
- hi  output  WIDTH  product[63:32] or remainder
- lo  output  WIDTH  product[31:0] or quotient

Behaviour:
- Reset, applied at any clock edge in any state, including mid-operation:
  - state returns to IDLE and the iteration counter clears to 0
  - hi=0, lo=0, busy=0, done=0, hiloWrite=0
  - the in-flight operation is discarded, with no hiloWrite pulse
- States are IDLE, RUN, FIXUP and DONE.
- IDLE:
  - start=1 at edge N latches op.
  - Signed ops latch |a| and |b| (two's-complement negate if MSB set), plus negResult and negRem flags.
  - Unsigned ops latch a and b unchanged.
  - The 64-bit accumulator and the counter clear; the next state is RUN.
  - start while not IDLE is ignored with no queuing; a and b may change freely after edge N.
- RUN lasts exactly 32 edges (N+1..N+32), with the counter running 0..31.
- Multiply step is right-shift shift-add: if acc[0]=1, add the multiplicand into acc[63:32] with a 33-bit carry, then shift acc right by 1.
- Divide step is restoring:
  - shift the {rem,quot} pair left by 1
  - trial-subtract the divisor from the remainder
  - if the result is non-negative, keep it and set quotient bit 1; otherwise restore
- At count 31 the state moves to FIXUP.
- FIXUP (edge N+33):
  - MULT negates the 64-bit product if negResult.
  - DIV negates the quotient if negResult (operand signs differ) and negates the remainder if negRem (dividend negative).
  - hi and lo are loaded and the state moves to DONE.
- DONE:
  - done=hiloWrite=1 for exactly one cycle, between edges N+33 and N+34.
  - The state returns to IDLE at edge N+34.
  - A start sampled at edge N+34 is accepted, giving back-to-back operation.
- hi and lo hold their last values until the next FIXUP or reset. They do not change during RUN.
- Divide by zero produces no trap:
  - the restoring algorithm yields quotient 0xFFFFFFFF and remainder = dividend, for DIVU and DIV alike
  - signed fix-up is suppressed for a zero divisor
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 with no trap.
- reset and start asserted in the same cycle: reset wins.

Optional Feature:
- Macro: MULDIV_ZERO_SKIP_EN.
- Defined:
  - In IDLE, if b==0 (all ops), or a==0 for MULT/MULTU, the unit skips RUN and goes straight to FIXUP.
  - done pulses 2 cycles after the start edge.
  - Results are identical to the full path: multiply gives 0/0; divide by zero gives hi=a, lo=0xFFFFFFFF.
  - busy covers only those cycles.
- Undefined: all operations take the fixed 34-cycle path.

Decomposition:
- Shared package holds:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11
  - state encoding for IDLE, RUN, FIXUP, DONE
  - ITER=32 and a counter-width constant
- One combinational sub-module, abs_neg_32, is natural. It provides conditional two's-complement negation and is reused for operand absolute value and result fix-up.
- Everything else stays in mult_div_unit.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge N -> done only in cycle N+33..N+34; hi=0xFFFFFFFE, lo=0x00000001; busy high N+1..N+34.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MULTU 5*6 followed by start with DIVU 9/4 at cycle +10 -> second start ignored; hi=0, lo=30. Then DIVU 9/4 issued on the done-return edge -> hi=1, lo=2 after another 34 cycles.
5. Reset asserted at RUN count 10 -> next edge busy=0, hi=lo=0, no done pulse; a fresh MULTU 2*3 then yields lo=6.
6. With MULTU_ZERO_SKIP_EN defined as MULDIV_ZERO_SKIP_EN, MULTU 0*123 -> done 2 cycles after start, hi=lo=0; without it, done at the 34-cycle mark with the same result.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - op/state encodings and iteration constants for mult_div_unit
package mult_div_unit_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/abs_neg_32.sv
// rtl/abs_neg_32.sv - conditional two's-complement negation (operand abs and result fix-up)
module abs_neg_32 #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU engine driving the HI/LO registers
// Optional MULDIV_ZERO_SKIP_EN: zero operands bypass RUN and go straight to FIXUP.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hiloWrite,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_div_in, neg_a_in, neg_b_in, accept;
  logic [WIDTH-1:0] abs_a, abs_b, quot_fix, rem_fix;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;

  assign is_div_in = op_is_div(op);
  assign neg_a_in  = op_is_signed(op) & a[WIDTH-1];
  assign neg_b_in  = op_is_signed(op) & b[WIDTH-1];
  // DONE also accepts so a new op can start on the edge that retires the old one
  assign accept    = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  abs_neg_32 #(.W(WIDTH)) u_abs_a     (.neg(neg_a_in), .x(a), .y(abs_a));
  abs_neg_32 #(.W(WIDTH)) u_abs_b     (.neg(neg_b_in), .x(b), .y(abs_b));
  abs_neg_32 #(.W(W2))    u_fix_prod  (.neg(~div_q & neg_res_q), .x(acc_q), .y(prod_fix));
  abs_neg_32 #(.W(WIDTH)) u_fix_quot  (.neg(div_q & neg_res_q), .x(acc_q[WIDTH-1:0]), .y(quot_fix));
  abs_neg_32 #(.W(WIDTH)) u_fix_rem   (.neg(div_q & neg_rem_q), .x(acc_q[W2-1:WIDTH]), .y(rem_fix));

  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
  assign rem_sh   = acc_q[W2-1:WIDTH-1];
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;

`ifdef MULDIV_ZERO_SKIP_EN
  logic skip_in;
  assign skip_in = (b == '0) | (~is_div_in & (a == '0));
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_RUN: begin
        if (div_q) begin
          acc_d = rem_ge ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                         : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    if (accept) begin
      div_d     = is_div_in;
      // a zero divisor leaves the quotient unsigned; negRem alone restores hi to the dividend
      neg_res_d = (a[WIDTH-1] ^ b[WIDTH-1]) & op_is_signed(op) & (~is_div_in | (b != '0));
      neg_rem_d = neg_a_in & is_div_in;
      opnd_d    = is_div_in ? abs_b : abs_a;
      acc_d     = {{WIDTH{1'b0}}, (is_div_in ? abs_a : abs_b)};
      cnt_d     = '0;
      state_d   = ST_RUN;
`ifdef MULDIV_ZERO_SKIP_EN
      if (skip_in) begin
        acc_d   = is_div_in ? {abs_a, {WIDTH{1'b1}}} : '0;
        state_d = ST_FIXUP;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign hiloWrite = done;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with an arithmetic reference model
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_i  = 2'b00;
  logic [31:0] a_i   = '0;
  logic [31:0] b_i   = '0;
  logic        busy, done, hiloWrite;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned when;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned busy_start = 0;
  int unsigned busy_end = 0;
  logic [31:0] hold_hi = '0;
  logic [31:0] hold_lo = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .hiloWrite(hiloWrite), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              sq, sr;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIVU) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {32'(sr), 32'(sq)};
      end
    endcase
  endfunction

  always @(negedge clock) begin
    check("busy", 64'(busy), 64'((cyc >= busy_start) && (cyc <= busy_end)));
    if (done || hiloWrite) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done | hiloWrite), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e.when));
        check("done", 64'(done), 64'd1);
        check("hiloWrite", 64'(hiloWrite), 64'd1);
        check("hi", 64'(hi), 64'(mon_e.hi));
        check("lo", 64'(lo), 64'(mon_e.lo));
        hold_hi = mon_e.hi;
        hold_lo = mon_e.lo;
      end
    end else begin
      check("hi_hold", 64'(hi), 64'(hold_hi));
      check("lo_hold", 64'(lo), 64'(hold_lo));
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int          t;
    exp_t        e;
    logic [63:0] r;
    logic        skip;
    t = 0;
    while (busy && !done) begin
      @(negedge clock); #1;
      t++;
      if (t > 100) begin
        check("ready_timeout", 64'(busy), 64'd0);
        return;
      end
    end
    start = 1'b1;
    op_i  = op;
    a_i   = a;
    b_i   = b;
    r     = ref_result(op, a, b);
    skip  = 1'b0;
`ifdef MULDIV_ZERO_SKIP_EN
    skip = (b == 0) || (!op[1] && a == 0);
`endif
    e.hi   = r[63:32];
    e.lo   = r[31:0];
    e.when = cyc + (skip ? 32'd2 : 32'd34);
    sb_q.push_back(e);
    busy_start = cyc + 1;
    busy_end   = e.when;
    @(negedge clock); #1;
    start = 1'b0;
    op_i  = 2'($urandom);
    a_i   = $urandom;
    b_i   = $urandom;
  endtask

  task automatic poke(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op_i  = op;
    a_i   = a;
    b_i   = b;
    @(negedge clock); #1;
    start = 1'b0;
  endtask

  task automatic apply_reset(input logic with_start);
    reset = 1'b1;
    start = with_start;
    op_i  = 2'($urandom);
    a_i   = $urandom;
    b_i   = $urandom;
    sb_q.delete();
    hold_hi    = '0;
    hold_lo    = '0;
    busy_start = 0;
    busy_end   = 0;
    @(negedge clock); #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clock); #1;
      t++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    int          t;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clock);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {32'(hi), 32'(lo)}, 64'd0);
    reset = 1'b0;

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd7);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(OP_DIVU,  32'd100, 32'd0);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd0);

    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (9) begin
      @(negedge clock); #1;
    end
    poke(OP_DIVU, 32'd9, 32'd4);
    issue(OP_DIVU, 32'd9, 32'd4);

    issue(OP_MULTU, $urandom, $urandom);
    repeat (10) begin
      @(negedge clock); #1;
    end
    apply_reset(1'b0);
    issue(OP_MULTU, 32'd2, 32'd3);

    wait_idle();
    apply_reset(1'b1);

    issue(OP_MULTU, 32'd0, 32'd123);
    issue(OP_MULT,  32'h8000_0000, 32'd0);

    for (int i = 0; i < 80; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'd0;
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        4: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock); #1;
      end
      issue(rop, ra, rb);
      if ($urandom_range(0, 3) == 0 && busy && !done) poke(2'($urandom), $urandom, $urandom);
    end

    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clock); #1;
      t++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
